// File: rtl/scanline_mixer_pkg.sv
// Shared constants and helpers for the scanline mixer: output width, rounding
// term, scanline period encodings and the colour-depth expansion function.
package scanline_mixer_pkg;

    localparam int OUT_W = 8;
    localparam int RND   = 8;

    localparam logic [1:0] SL_OFF  = 2'd0;
    localparam logic [1:0] SL_1IN2 = 2'd1;
    localparam logic [1:0] SL_1IN3 = 2'd2;
    localparam logic [1:0] SL_1IN4 = 2'd3;

    // Left-justify a cw-bit value (held in the low bits) and fill the rest by
    // repeating its bits MSB first, so full scale maps to 0xFF.
    function automatic logic [OUT_W-1:0] expand_cw(input logic [OUT_W-1:0] value, input int cw);
        logic [OUT_W-1:0] res;
        int               idx;
        res = '0;
        for (int i = 0; i < OUT_W; i++) begin
            idx                = cw - 1 - (i % cw);
            res[OUT_W - 1 - i] = value[idx[2:0]];
        end
        return res;
    endfunction

endpackage

// File: rtl/scanline_mixer_sync_polarity_detect.sv
// Sync polarity detector: measures high and low time of sync_in in ticks and,
// at each rising edge, flags the sync as negative when it spent longer high.
module sync_polarity_detect
    import scanline_mixer_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic tick,
    input  logic sync_in,
    output logic neg_out
);

    logic             sync_q;
    logic [CNT_W-1:0] hi_q, hi_d;
    logic [CNT_W-1:0] lo_q, lo_d;
    logic             neg_q, neg_d;

    always_comb begin
        hi_d  = hi_q;
        lo_d  = lo_q;
        neg_d = neg_q;
        if (sync_in && !sync_q) begin
            neg_d = (hi_q > lo_q);
            hi_d  = '0;
            lo_d  = '0;
        end else if (tick) begin
            if (sync_in) begin
                if (hi_q != '1) hi_d = hi_q + 1'b1;
            end else if (lo_q != '1) begin
                lo_d = lo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            neg_q  <= 1'b0;
        end else begin
            sync_q <= sync_in;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            neg_q  <= neg_d;
        end
    end

    assign neg_out = neg_q;

endmodule

// File: rtl/scanline_mixer.sv
// Video output mixer: depth expansion, 1-in-N scanline attenuation, frame-aligned DE.
// Define SCANLINE_MIXER_POLARITY_DETECT_EN to build the automatic sync polarity normaliser.
module scanline_mixer
    import scanline_mixer_pkg::*;
#(
    parameter int CW    = 8,
    parameter int CNT_W = 12
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [CW-1:0] r_in,
    input  logic [CW-1:0] g_in,
    input  logic [CW-1:0] b_in,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hb_in,
    input  logic          vb_in,
    input  logic [3:0]    sl_level,
    input  logic [1:0]    sl_period,
    output logic [7:0]    vga_r,
    output logic [7:0]    vga_g,
    output logic [7:0]    vga_b,
    output logic          vga_hs,
    output logic          vga_vs,
    output logic          vga_de,
    output logic          ce_pix_out
);

    if (CW < 1 || CW > OUT_W || CNT_W < 1) begin : g_param_check
        $error("scanline_mixer: CW must be 1..8 and CNT_W at least 1");
    end

    logic       hs_neg, vs_neg;
    logic       hs, vs, hde;
    logic       hs_q, vs_q, hde_q, ce1_q;
    logic       de_q, de_d;
    logic [1:0] line_cnt_q, line_cnt_d, last_line;
    logic       dark;
    logic [3:0] lvl;
    logic [4:0] weight;
    logic       hs_out_q, vs_out_q, de_out_q, ce_out_q;

`ifdef SCANLINE_MIXER_POLARITY_DETECT_EN
    logic hs_in_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) hs_in_q <= 1'b0;
        else          hs_in_q <= hs_in;
    end

    sync_polarity_detect #(.CNT_W(CNT_W)) u_hs_pol (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (ce_pix),
        .sync_in (hs_in),
        .neg_out (hs_neg)
    );

    // Frame polarity is measured in lines, so the tick is the raw hs rising edge.
    sync_polarity_detect #(.CNT_W(CNT_W)) u_vs_pol (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .tick    (hs_in & ~hs_in_q),
        .sync_in (vs_in),
        .neg_out (vs_neg)
    );
`else
    assign hs_neg = 1'b0;
    assign vs_neg = 1'b0;
`endif

    always_comb begin
        hs  = hs_in ^ hs_neg;
        vs  = vs_in ^ vs_neg;
        hde = ~hb_in;
        case (sl_period)
            SL_1IN2: last_line = 2'd1;
            SL_1IN3: last_line = 2'd2;
            SL_1IN4: last_line = 2'd3;
            default: last_line = 2'd0;
        endcase
        line_cnt_d = line_cnt_q;
        if (vs_q && !vs) begin
            line_cnt_d = '0;
        end else if (hs_q && !hs) begin
            // >= rather than == so a shortened period wraps cleanly mid-frame.
            line_cnt_d = (line_cnt_q >= last_line) ? 2'd0 : line_cnt_q + 2'd1;
        end
        dark   = (sl_period != SL_OFF) && (line_cnt_q == last_line);
        lvl    = dark ? sl_level : 4'd0;
        weight = 5'd16 - {1'b0, lvl};
        de_d   = de_q;
        if (hde && !hde_q)      de_d = ~vb_in;
        else if (!hde && hde_q) de_d = 1'b0;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hde_q      <= 1'b0;
            de_q       <= 1'b0;
            ce1_q      <= 1'b0;
            line_cnt_q <= '0;
            hs_out_q   <= 1'b0;
            vs_out_q   <= 1'b0;
            de_out_q   <= 1'b0;
            ce_out_q   <= 1'b0;
        end else begin
            hs_q       <= hs;
            vs_q       <= vs;
            hde_q      <= hde;
            de_q       <= de_d;
            ce1_q      <= ce_pix;
            line_cnt_q <= line_cnt_d;
            hs_out_q   <= hs_q;
            vs_out_q   <= vs_q;
            de_out_q   <= de_q;
            ce_out_q   <= ce1_q;
        end
    end

    logic [CW-1:0] c_in [3];
    assign c_in[0] = r_in;
    assign c_in[1] = g_in;
    assign c_in[2] = b_in;

    for (genvar gi = 0; gi < 3; gi++) begin : g_ch
        logic [OUT_W-1:0] c8;
        logic [11:0]      prod_d, prod_q, rnd;
        logic [OUT_W-1:0] out_d, out_q;

        // c8 * (16 - lvl) peaks at 4080, so 12 bits hold product and rounding.
        always_comb begin
            c8     = expand_cw(8'(c_in[gi]), CW);
            prod_d = {4'b0, c8} * {7'b0, weight};
            rnd    = prod_q + 12'(RND);
            out_d  = rnd[11:4];
        end

        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                prod_q <= '0;
                out_q  <= '0;
            end else begin
                prod_q <= prod_d;
                out_q  <= out_d;
            end
        end
    end

    assign vga_r      = g_ch[0].out_q;
    assign vga_g      = g_ch[1].out_q;
    assign vga_b      = g_ch[2].out_q;
    assign vga_hs     = hs_out_q;
    assign vga_vs     = vs_out_q;
    assign vga_de     = de_out_q;
    assign ce_pix_out = ce_out_q;

endmodule

// File: tb/tb_scanline_mixer.sv
// Directed bench for scanline_mixer: three depths (CW 8/4/1) share one stimulus,
// expectations are queued at drive time and checked two clocks later.
module tb_scanline_mixer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, ce, hs, vs, hb, vb;
    logic [7:0] r, g, b;
    logic [3:0] lvl;
    logic [1:0] per;

    logic [7:0] o8_r, o8_g, o8_b, o4_r, o4_g, o4_b, o1_r, o1_g, o1_b;
    logic       o8_hs, o8_vs, o8_de, o8_ce;
    logic       o4_hs, o4_vs, o4_de, o4_ce;
    logic       o1_hs, o1_vs, o1_de, o1_ce;

    scanline_mixer #(.CW(8)) u_dut8 (
        .clk_sys(clk), .reset_n(rst_n), .ce_pix(ce),
        .r_in(r), .g_in(g), .b_in(b),
        .hs_in(hs), .vs_in(vs), .hb_in(hb), .vb_in(vb),
        .sl_level(lvl), .sl_period(per),
        .vga_r(o8_r), .vga_g(o8_g), .vga_b(o8_b),
        .vga_hs(o8_hs), .vga_vs(o8_vs), .vga_de(o8_de), .ce_pix_out(o8_ce)
    );

    scanline_mixer #(.CW(4)) u_dut4 (
        .clk_sys(clk), .reset_n(rst_n), .ce_pix(ce),
        .r_in(r[3:0]), .g_in(g[3:0]), .b_in(b[3:0]),
        .hs_in(hs), .vs_in(vs), .hb_in(hb), .vb_in(vb),
        .sl_level(lvl), .sl_period(per),
        .vga_r(o4_r), .vga_g(o4_g), .vga_b(o4_b),
        .vga_hs(o4_hs), .vga_vs(o4_vs), .vga_de(o4_de), .ce_pix_out(o4_ce)
    );

    scanline_mixer #(.CW(1)) u_dut1 (
        .clk_sys(clk), .reset_n(rst_n), .ce_pix(ce),
        .r_in(r[0:0]), .g_in(g[0:0]), .b_in(b[0:0]),
        .hs_in(hs), .vs_in(vs), .hb_in(hb), .vb_in(vb),
        .sl_level(lvl), .sl_period(per),
        .vga_r(o1_r), .vga_g(o1_g), .vga_b(o1_b),
        .vga_hs(o1_hs), .vga_vs(o1_vs), .vga_de(o1_de), .ce_pix_out(o1_ce)
    );

    logic [2:0][7:0] obs_r, obs_g, obs_b;
    logic [2:0]      obs_hs, obs_vs, obs_de, obs_ce;
    assign obs_r  = {o1_r, o4_r, o8_r};
    assign obs_g  = {o1_g, o4_g, o8_g};
    assign obs_b  = {o1_b, o4_b, o8_b};
    assign obs_hs = {o1_hs, o4_hs, o8_hs};
    assign obs_vs = {o1_vs, o4_vs, o8_vs};
    assign obs_de = {o1_de, o4_de, o8_de};
    assign obs_ce = {o1_ce, o4_ce, o8_ce};

    // mask bits: 0 colour, 1 hs, 2 vs, 3 de, 4 ce
    typedef struct packed {
        logic [4:0]      mask;
        logic [2:0][7:0] er, eg, eb;
        logic            ehs, evs, ede, ece;
    } exp_t;

    localparam logic [4:0] ALL = 5'b11111;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic exp_hneg = 1'b0;
    logic exp_vneg = 1'b0;
    logic ce_force = 1'b0;

    function automatic logic [7:0] att(input logic [7:0] c, input logic [3:0] l);
        int t;
        t = (int'(c) * (16 - int'(l)) + 8) / 16;
        return t[7:0];
    endfunction

    // index 0: CW=8, 1: CW=4 (low nibble repeated), 2: CW=1 (bit 0 repeated)
    function automatic logic [2:0][7:0] exp3(input logic [7:0] v, input logic [3:0] l);
        logic [2:0][7:0] e;
        e[0] = att(v, l);
        e[1] = att({v[3:0], v[3:0]}, l);
        e[2] = att({8{v[0]}}, l);
        return e;
    endfunction

    function automatic int cw_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 1;
    endfunction

    task automatic chk(input string tag, input int d, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cw%0d observed=%02h expected=%02h", tag, cw_of(d), obs, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        for (int d = 0; d < 3; d++) begin
            if (e.mask[0]) begin
                chk("r", d, obs_r[d], e.er[d]);
                chk("g", d, obs_g[d], e.eg[d]);
                chk("b", d, obs_b[d], e.eb[d]);
            end
            if (e.mask[1]) chk("hs", d, {7'b0, obs_hs[d]}, {7'b0, e.ehs});
            if (e.mask[2]) chk("vs", d, {7'b0, obs_vs[d]}, {7'b0, e.evs});
            if (e.mask[3]) chk("de", d, {7'b0, obs_de[d]}, {7'b0, e.ede});
            if (e.mask[4]) chk("ce", d, {7'b0, obs_ce[d]}, {7'b0, e.ece});
        end
    endtask

    task automatic reset_chk(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_r"}, d, obs_r[d], 8'h00);
            chk({tag, "_g"}, d, obs_g[d], 8'h00);
            chk({tag, "_b"}, d, obs_b[d], 8'h00);
            chk({tag, "_hs"}, d, {7'b0, obs_hs[d]}, 8'h00);
            chk({tag, "_vs"}, d, {7'b0, obs_vs[d]}, 8'h00);
            chk({tag, "_de"}, d, {7'b0, obs_de[d]}, 8'h00);
            chk({tag, "_ce"}, d, {7'b0, obs_ce[d]}, 8'h00);
        end
    endtask

    task automatic cyc(input logic hs_v, input logic vs_v, input logic hb_v, input logic vb_v,
                       input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv,
                       input logic dim, input logic de_e, input logic [4:0] mask);
        exp_t       e;
        logic [3:0] l;
        @(negedge clk);
        hs = hs_v; vs = vs_v; hb = hb_v; vb = vb_v;
        r = rv; g = gv; b = bv;
        ce = ce_force ? 1'b1 : ~ce;
        l = dim ? lvl : 4'd0;
        e.mask = mask;
        e.er   = exp3(rv, l);
        e.eg   = exp3(gv, l);
        e.eb   = exp3(bv, l);
        e.ehs  = hs_v ^ exp_hneg;
        e.evs  = vs_v ^ exp_vneg;
        e.ede  = de_e;
        e.ece  = ce;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() >= 2) check_entry(q.pop_front());
    endtask

    // 8 active pixels then 4 blanking cycles carrying a 2-cycle hs pulse.
    task automatic line_t(input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv,
                          input logic dim, input logic vba, input logic vbm);
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, 1'b0, (i < 4) ? vba : vbm, rv, gv, bv, dim, ~vba, ALL);
        for (int i = 0; i < 4; i++)
            cyc((i == 1 || i == 2), 1'b0, 1'b1, vbm, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALL);
    endtask

    // vs and hs fall in the same cycle: the vs clear must win.
    task automatic vsync_t();
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALL);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALL);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALL);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, ALL);
    endtask

    task automatic flush_t();
        repeat (2) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 5'b0);
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b0; hs = 1'b0; vs = 1'b0; hb = 1'b1; vb = 1'b0;
        r = '0; g = '0; b = '0; lvl = 4'd0; per = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        reset_chk("rst_init");
        @(negedge clk);
        rst_n = 1'b1;

        // identity path: scanlines off, level ignored
        per = 2'd0; lvl = 4'd5;
        vsync_t();
        line_t(8'h5A, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        line_t(8'h5A, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0);
        // depth expansion
        line_t(8'h0A, 8'h03, 8'h0F, 1'b0, 1'b0, 1'b0);
        line_t(8'h01, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);

        // 1-in-2 at half level
        per = 2'd1; lvl = 4'd8;
        vsync_t();
        for (int i = 0; i < 4; i++) line_t(8'hC8, 8'hC8, 8'hC8, i[0], 1'b0, 1'b0);
        // 1-in-4
        per = 2'd3;
        vsync_t();
        for (int i = 0; i < 8; i++) line_t(8'hC8, 8'h40, 8'hFF, (i % 4 == 3), 1'b0, 1'b0);
        // extreme levels
        per = 2'd1; lvl = 4'd15;
        vsync_t();
        line_t(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        line_t(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        lvl = 4'd0;
        line_t(8'hFF, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0);
        line_t(8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);

        // data enable: vb drops mid-line and during blanking
        per = 2'd0;
        vsync_t();
        line_t(8'h33, 8'h44, 8'h55, 1'b0, 1'b1, 1'b1);
        line_t(8'h33, 8'h44, 8'h55, 1'b0, 1'b1, 1'b0);
        line_t(8'h33, 8'h44, 8'h55, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-line on a darkened line
        per = 2'd1; lvl = 4'd8;
        vsync_t();
        line_t(8'hC8, 8'hC8, 8'hC8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'hC8, 8'hC8, 8'hC8, 1'b1, 1'b1, ALL);
        #1;
        rst_n = 1'b0;
        #1;
        reset_chk("rst_mid");
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        vsync_t();
        line_t(8'hC8, 8'hC8, 8'hC8, 1'b0, 1'b0, 1'b0);
        line_t(8'hC8, 8'hC8, 8'hC8, 1'b1, 1'b0, 1'b0);
        flush_t();

`ifdef SCANLINE_MIXER_POLARITY_DETECT_EN
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        ce_force = 1'b1; exp_hneg = 1'b0; exp_vneg = 1'b0; per = 2'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        // negative hs: low 96, high 704
        for (int ln = 0; ln < 3; ln++) begin
            if (ln == 2) exp_hneg = 1'b1;
            for (int c = 0; c < 800; c++)
                cyc(c >= 96, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                    (ln == 2) ? 5'b00010 : 5'b00000);
        end
        // negative vs: low 2 lines of 525, short 10-clock lines
        for (int f = 0; f < 3; f++) begin
            if (f == 2) exp_vneg = 1'b1;
            for (int ln = 0; ln < 525; ln++)
                for (int c = 0; c < 10; c++)
                    cyc(c >= 2, ln >= 2, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0,
                        (f == 2) ? 5'b00110 : 5'b00000);
        end
        flush_t();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scanline_mixer.md
# scanline_mixer

Parametrised video output mixer that sits between a core's pixel pipeline and the VGA/HDMI output stage. It expands native-depth RGB to 8 bits per channel and applies programmable scanline attenuation with a selectable 1-in-N line pattern. It also generates a frame-aligned data-enable and, optionally, normalises sync polarity. It is the successor to the fixed 2-bit-scanline mixer: it adds arbitrary input depth, 16-level intensity, line period selection and a reset.

## Interface
Parameters:
- CW, 8: input bits per colour channel, legal range 1..8.
- CNT_W, 12: width of the polarity-detect counters (saturating).

Ports:
- clk_sys  in  1  system clock; the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- ce_pix  in  1  pixel clock enable.
- r_in, g_in, b_in  in  CW each  pixel colour.
- hs_in, vs_in, hb_in, vb_in  in  1 each  sync and blanking; blanks are active-high.
- sl_level  in  4  attenuation on darkened lines; 0 = none, 15 = 15/16 dimmed.
- sl_period  in  2  0 = scanlines off; 1/2/3 = darken 1 line in every 2/3/4.
- vga_r, vga_g, vga_b  out  8 each  output colour.
- vga_hs, vga_vs  out  1 each  output sync, active-high after normalisation.
- vga_de  out  1  data enable.
- ce_pix_out  out  1  ce_pix delayed to match the pipeline.

## Operation
- **Expansion.** c8 is the CW-bit value left-justified and filled by MSB-first bit replication. With CW=4, 0xA becomes 0xAA. With CW=1, 1 becomes 0xFF.
- **Sync normalisation.** hs = hs_in ^ hs_neg and vs = vs_in ^ vs_neg. Both flags are constant 0 when the detector is compiled out.
- **Line counter (line_cnt, 2 bits).**
  - Increments on each hs falling edge (end of active sync).
  - Wraps to 0 when it reaches N-1, where N = sl_period+1.
  - Clears to 0 on each vs falling edge. If hs and vs fall in the same cycle, the vs clear wins.
- **Darkening rule.** A line is darkened when sl_period != 0 and line_cnt == N-1.
- **Attenuation.** out = (c8 × (16 − lvl) + 8) >> 4. lvl is sl_level on darkened lines and 0 otherwise.
  - The intermediate result is 12 bits; no clamp is needed (255 maps to 255).
  - lvl = 0 is an exact identity.
- **Data enable.**
  - hde = ~hb_in and vde = ~vb_in.
  - On an hde rising edge, vga_de takes vde.
  - On an hde falling edge, vga_de goes to 0.
  - Otherwise vga_de holds.
- **Mid-frame changes.**
  - A change to sl_level takes effect on the next pixel.
  - A change to sl_period takes effect immediately. If line_cnt ≥ N−1, the counter wraps to 0 at the next hs falling edge.

## Timing
- **Clocking.** The pipeline advances on every clk_sys cycle regardless of ce_pix.
- **Latency.** Exactly 2 clk_sys cycles from inputs to every output: colour, vga_hs, vga_vs, vga_de and ce_pix_out.
  - Stage 1: expansion, multiply and sync/DE registration.
  - Stage 2: rounding, shift and output registers.
- **Edge detection.** Uses the previous-cycle registered value of each signal.
- **Reset.** Asynchronous and active-low; it applies equally when asserted mid-frame. Every output resets to 0. line_cnt, the edge registers, both polarity flags and all counters also reset to 0.
- **After reset.** The first vs falling edge aligns the line pattern.

## Configuration
- Macro: SCANLINE_MIXER_POLARITY_DETECT_EN.
- **Defined:** two detector instances run.
  - **hs detector.** Counts ce_pix cycles while hs_in is high and while it is low, in separate CNT_W-bit saturating counters.
  - On each hs_in rising edge, it sets hs_neg <= (hi_cnt > lo_cnt) and then clears both counters.
  - **vs detector.** Identical, but counts hs_in rising edges instead of ce_pix cycles.
  - The flags update once per period, so a polarity change settles after one full line or frame.
- **Undefined:** hs_neg = vs_neg = 0, and no counters are synthesised.

## Structure
- **Package scanline_mixer_pkg** holds:
  - the output width constant (8);
  - the rounding constant (8);
  - the sl_period encoding constants;
  - the function expand_cw(value, cw) for bit replication.
- **Sub-module sync_polarity_detect** has ports clk_sys, reset_n, tick, sync_in and neg_out, with parameter CNT_W. It is instantiated twice, for hs and vs, only under the macro.

## Test plan
- **Identity path:** CW=8, sl_period=0, pixel 0x5A/0x00/0xFF → vga_r/g/b = 0x5A/0x00/0xFF exactly 2 clocks later; syncs aligned with the colour.
- **Depth expansion:** CW=4, input 0xA/0x3/0xF → output 0xAA/0x33/0xFF. CW=1, input 1 → 0xFF.
- **Scanline pattern:** sl_period=1, sl_level=8, constant 0xC8 input → lines alternate 0xC8 and 0x64, with the 1st line after a vs falling edge undimmed. With sl_period=3, every 4th line is 0x64.
- **Extreme levels:** sl_level=15 on input 0xFF → 0x10 on darkened lines. sl_level=0 → 0xFF unchanged.
- **Data enable and reset:**
  - Drop vb_in while hb_in is high → vga_de stays 0 until the next hb_in fall.
  - Pulse reset_n low mid-line → all outputs are 0 asynchronously.
  - After release, line_cnt restarts at the next vs falling edge.
- **Polarity detect (macro on):** hs_in low for 96 clocks and high for 704 → after one line, vga_hs is high during the 96-clock pulse. Apply the same check to vs using a 2-line low period in a 525-line frame.
